// File: rtl/knn_query_sequencer_if.sv
// Interface between the query source / result consumer, the k-NN classifier
// and the query sequencer. The sequencer connects through the slave modport.
interface knn_query_sequencer_if #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned NUM_FEATURES = 2,
    parameter int unsigned TAG_WIDTH    = 4
);
    // Query side
    logic                               q_valid;
    logic                               q_ready;
    logic [DATA_WIDTH*NUM_FEATURES-1:0] q_data;
    logic [DATA_WIDTH-1:0]              q_k;
    // Classifier side
    logic                               knn_start;
    logic [DATA_WIDTH*NUM_FEATURES-1:0] knn_test_data;
    logic [DATA_WIDTH-1:0]              knn_k_value;
    logic                               knn_done;
    logic                               knn_class;
    // Result side
    logic                               r_valid;
    logic                               r_ready;
    logic                               r_class;
    logic [TAG_WIDTH-1:0]               r_tag;
    logic [1:0]                         r_status;

    modport slave (
        input  q_valid, q_data, q_k, knn_done, knn_class, r_ready,
        output q_ready, knn_start, knn_test_data, knn_k_value,
               r_valid, r_class, r_tag, r_status
    );

    modport master (
        output q_valid, q_data, q_k, knn_done, knn_class, r_ready,
        input  q_ready, knn_start, knn_test_data, knn_k_value,
               r_valid, r_class, r_tag, r_status
    );
endinterface

// File: rtl/knn_query_sequencer.sv
// Host-side initiator for the k-NN classifier: queues queries in a small FIFO,
// issues them one at a time, and returns each result with its sequence tag
// and a status code (00 ok, 01 timeout, 10 bad k).
module knn_query_sequencer #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned NUM_FEATURES   = 2,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TAG_WIDTH      = 4,
    parameter int unsigned MAX_K          = 15,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                        clk,
    input  logic                        rst_n,
    knn_query_sequencer_if.slave        bus,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] q_count
);
    localparam int unsigned TD_W  = DATA_WIDTH * NUM_FEATURES;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned ENT_W = TD_W + DATA_WIDTH + TAG_WIDTH;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESULT} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ENT_W-1:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [TAG_WIDTH-1:0]  r_tag_cnt;
    logic                  r_q_ready;
    logic                  r_knn_start;
    logic [TD_W-1:0]       r_test_data;
    logic [DATA_WIDTH-1:0] r_k_value;
    logic                  r_r_valid;
    logic                  r_class;
    logic [TAG_WIDTH-1:0]  r_tag;
    logic [1:0]            r_status;
    logic                  r_busy;
    logic [TMR_W-1:0]      r_timer;
    logic                  r_armed;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_bad_k;
    logic                  w_done_ok;
    logic                  w_timeout;
    logic [CNT_W-1:0]      w_count_next;
    logic [TD_W-1:0]       w_head_data;
    logic [DATA_WIDTH-1:0] w_head_k;
    logic [TAG_WIDTH-1:0]  w_head_tag;

    assign {w_head_data, w_head_k, w_head_tag} = r_mem[r_rd_ptr];
    assign w_push       = bus.q_valid && r_q_ready;
    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    assign bus.q_ready       = r_q_ready;
    assign bus.knn_start     = r_knn_start;
    assign bus.knn_test_data = r_test_data;
    assign bus.knn_k_value   = r_k_value;
    assign bus.r_valid       = r_r_valid;
    assign bus.r_class       = r_class;
    assign bus.r_tag         = r_tag;
    assign bus.r_status      = r_status;
    assign busy              = r_busy;
    assign q_count           = r_count;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state decode and per-cycle control strobes
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_bad_k      = 1'b0;
        w_done_ok    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_count != '0) begin
                    w_pop = 1'b1;
                    if ((w_head_k == '0) || (w_head_k > DATA_WIDTH'(MAX_K))) begin
                        w_bad_k      = 1'b1;
                        w_state_next = ST_RESULT;
                    end else begin
                        w_state_next = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: w_state_next = ST_WAIT;
            ST_WAIT: begin
                // A done level left over from the previous query only counts
                // once it has been seen low during this wait.
                if (bus.knn_done && r_armed) begin
                    w_done_ok    = 1'b1;
                    w_state_next = ST_RESULT;
                end else if (r_timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_RESULT;
                end
            end
            ST_RESULT: if (bus.r_ready) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // FIFO storage; contents are qualified by the occupancy count
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {bus.q_data, bus.q_k, r_tag_cnt};
    end

    // FIFO pointers, tag counter, timer and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_tag_cnt   <= '0;
            r_q_ready   <= 1'b0;
            r_knn_start <= 1'b0;
            r_test_data <= '0;
            r_k_value   <= '0;
            r_r_valid   <= 1'b0;
            r_class     <= 1'b0;
            r_tag       <= '0;
            r_status    <= 2'b00;
            r_busy      <= 1'b0;
            r_timer     <= '0;
            r_armed     <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr  <= r_wr_ptr + PTR_W'(1);
                r_tag_cnt <= r_tag_cnt + TAG_WIDTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_tag    <= w_head_tag;
                if (!w_bad_k) begin
                    r_test_data <= w_head_data;
                    r_k_value   <= w_head_k;
                end
            end
            r_count     <= w_count_next;
            r_q_ready   <= (w_count_next != CNT_W'(FIFO_DEPTH));
            r_knn_start <= (w_state_next == ST_ISSUE);
            r_r_valid   <= (w_state_next == ST_RESULT);
            r_busy      <= (w_state_next != ST_IDLE);

            if (r_state == ST_ISSUE) begin
                r_timer <= '0;
                r_armed <= 1'b0;
            end else if (r_state == ST_WAIT) begin
                r_timer <= r_timer + TMR_W'(1);
                if (!bus.knn_done) r_armed <= 1'b1;
            end

            if (w_done_ok) begin
                r_class  <= bus.knn_class;
                r_status <= 2'b00;
            end else if (w_timeout) begin
                r_class  <= 1'b0;
                r_status <= 2'b01;
            end else if (w_bad_k) begin
                r_class  <= 1'b0;
                r_status <= 2'b10;
            end
        end
    end
endmodule

// File: tb/tb_knn_query_sequencer.sv
// Directed bench for knn_query_sequencer with a behavioural classifier model.
module tb_knn_query_sequencer;
    logic       clk;
    logic       rst_n;
    logic       busy;
    logic [2:0] q_count;

    knn_query_sequencer_if #(.DATA_WIDTH(8), .NUM_FEATURES(2), .TAG_WIDTH(4)) bus ();

    knn_query_sequencer #(
        .DATA_WIDTH(8), .NUM_FEATURES(2), .FIFO_DEPTH(4),
        .TAG_WIDTH(4), .MAX_K(15), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .q_count(q_count)
    );

    typedef struct {
        logic [15:0] data;
        logic [7:0]  k;
        logic        cls;
        logic [3:0]  tag;
        logic [1:0]  status;
    } vec_t;

    typedef struct {
        logic       cls;
        logic [3:0] tag;
        logic [1:0] status;
        int         first;
    } res_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    // classifier model controls
    int   m_low = 1, m_high = 20;
    bit   m_never = 0, m_never_cur = 0;
    bit   m_active = 0;
    int   m_cnt = 0;
    int   starts = 0;
    int   last_start = 0;
    // result monitor
    res_t res_q [64];
    int   res_n = 0;
    logic rv_prev = 0;
    int   rv_first = 0;
    int   qmax = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Classifier model: drops done m_low cycles after start, raises it with
    // class = ~feature0[0] m_high cycles after start, then holds it high.
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.knn_done  <= 1'b0;
            bus.knn_class <= 1'b0;
            m_active      <= 1'b0;
            m_cnt         <= 0;
        end else begin
            if (m_active) begin
                if (m_cnt + 1 == m_low) bus.knn_done <= 1'b0;
                if (m_cnt + 1 == m_high && !m_never_cur) begin
                    bus.knn_done  <= 1'b1;
                    bus.knn_class <= ~bus.knn_test_data[8];
                    m_active      <= 1'b0;
                end
                m_cnt <= m_cnt + 1;
            end
            if (bus.knn_start) begin
                starts      <= starts + 1;
                last_start  <= cyc;
                m_active    <= 1'b1;
                m_cnt       <= 0;
                m_never_cur <= m_never;
            end
        end
    end

    // Result monitor: records each completed handshake and when r_valid rose
    always @(negedge clk) begin
        rv_prev <= bus.r_valid;
        if (bus.r_valid && !rv_prev) rv_first <= cyc;
        if (bus.r_valid && bus.r_ready && res_n < 64) begin
            res_q[res_n].cls    <= bus.r_class;
            res_q[res_n].tag    <= bus.r_tag;
            res_q[res_n].status <= bus.r_status;
            res_q[res_n].first  <= rv_prev ? rv_first : cyc;
            res_n               <= res_n + 1;
        end
        if (int'(q_count) > qmax) qmax <= int'(q_count);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        chk(name, {bus.q_ready, bus.knn_start, bus.knn_test_data, bus.knn_k_value,
                   bus.r_valid, bus.r_class, bus.r_tag, bus.r_status, busy, q_count}, 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        bus.q_valid = 0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        chk_zero("reset_outputs");
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic push(input logic [15:0] d, input logic [7:0] k, output int acc);
        logic rdy;
        bit   got = 0;
        acc = 0;
        bus.q_valid = 1; bus.q_data = d; bus.q_k = k;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            rdy = bus.q_ready;
            @(posedge clk); #1;
            if (rdy) begin
                got = 1;
                acc = cyc;
            end
        end
        bus.q_valid = 0;
        if (!got) chk("push_timeout", 64'd0, 64'd1);
    endtask

    task automatic get_res(input int idx, output res_t r);
        bit got = 0;
        r = '{cls: 1'b0, tag: 4'd0, status: 2'd0, first: 0};
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk); #1;
            if (res_n > idx) got = 1;
        end
        if (got) r = res_q[idx];
        else chk("result_timeout", 64'(res_n), 64'(idx + 1));
    endtask

    task automatic chk_res(input string name, input int idx, input vec_t v, output res_t r);
        get_res(idx, r);
        chk({name, "_class"},  64'(r.cls),    64'(v.cls));
        chk({name, "_tag"},    64'(r.tag),    64'(v.tag));
        chk({name, "_status"}, 64'(r.status), 64'(v.status));
    endtask

    task automatic wait_start(input int base);
        bit got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk); #1;
            if (starts > base) got = 1;
        end
        if (!got) chk("start_timeout", 64'(starts), 64'(base + 1));
    endtask

    initial begin
        vec_t t2 [5];
        vec_t t5 [3];
        vec_t v;
        res_t r;
        int   acc, acc0, sb, base, s0, rn, bad;
        logic c_cls;
        logic [3:0] c_tag;
        logic [1:0] c_st;

        // {data, k, expected class, expected tag, expected status}
        t2[0] = '{16'h0408, 8'd5, 1'b1, 4'd0, 2'b00};
        t2[1] = '{16'h0203, 8'd5, 1'b1, 4'd1, 2'b00};
        t2[2] = '{16'h0707, 8'd5, 1'b0, 4'd2, 2'b00};
        t2[3] = '{16'h0101, 8'd5, 1'b0, 4'd3, 2'b00};
        t2[4] = '{16'h0808, 8'd5, 1'b1, 4'd4, 2'b00};
        t5[0] = '{16'h0102, 8'd0,  1'b0, 4'd0, 2'b10};
        t5[1] = '{16'h0304, 8'd16, 1'b0, 4'd1, 2'b10};
        t5[2] = '{16'h0606, 8'd15, 1'b1, 4'd2, 2'b00};

        rst_n = 1;
        bus.q_valid = 0; bus.q_data = '0; bus.q_k = '0; bus.r_ready = 0;

        // Single query (4,8) k=3, done 20 cycles after start
        do_reset();
        bus.r_ready = 1;
        m_low = 1; m_high = 20; m_never = 0;
        sb = starts; base = res_n;
        push(16'h0408, 8'd3, acc);
        v = '{16'h0408, 8'd3, 1'b1, 4'd0, 2'b00};
        chk_res("single", base, v, r);
        chk("single_starts", 64'(starts - sb), 64'd1);
        chk("single_test_data", 64'(bus.knn_test_data), 64'h0408);
        chk("single_k_value", 64'(bus.knn_k_value), 64'd3);
        chk("single_start_latency", 64'(last_start - acc), 64'd1);
        chk("single_result_latency", 64'(r.first - last_start), 64'd21);

        // Five back-to-back queries; FIFO fills while the first is in flight
        do_reset();
        m_low = 1; m_high = 6;
        base = res_n;
        foreach (t2[i]) push(t2[i].data, t2[i].k, acc);
        chk("burst_q_ready_full", 64'(bus.q_ready), 64'd0);
        chk("burst_q_count_full", 64'(q_count), 64'd4);
        foreach (t2[i]) chk_res($sformatf("burst%0d", i), base + i, t2[i], r);

        // Done still high from the previous query; must wait for the new rise
        m_low = 2; m_high = 8;
        base = res_n;
        push(16'h0305, 8'd2, acc);
        v = '{16'h0305, 8'd2, 1'b0, 4'd5, 2'b00};
        chk_res("stale", base, v, r);
        chk("stale_latency", 64'(r.first - last_start), 64'd9);

        // Classifier never answers: timeout, then the queued query runs
        do_reset();
        m_low = 1; m_high = 5; m_never = 1;
        sb = starts; base = res_n;
        push(16'h0506, 8'd4, acc);
        wait_start(sb);
        s0 = last_start;
        m_never = 0;
        push(16'h0203, 8'd2, acc);
        v = '{16'h0506, 8'd4, 1'b0, 4'd0, 2'b01};
        chk_res("timeout", base, v, r);
        chk("timeout_latency", 64'(r.first - s0), 64'd65);
        v = '{16'h0203, 8'd2, 1'b1, 4'd1, 2'b00};
        chk_res("after_timeout", base + 1, v, r);
        chk("after_timeout_starts", 64'(starts - sb), 64'd2);

        // Illegal k values, bounded by the legal maximum
        do_reset();
        m_low = 1; m_high = 5;
        sb = starts; base = res_n;
        acc0 = 0;
        foreach (t5[i]) begin
            push(t5[i].data, t5[i].k, acc);
            if (i == 0) acc0 = acc;
        end
        foreach (t5[i]) begin
            chk_res($sformatf("badk%0d", i), base + i, t5[i], r);
            if (i == 0) chk("badk_latency", 64'(r.first - acc0), 64'd1);
        end
        chk("badk_starts", 64'(starts - sb), 64'd1);

        // Back-pressure on the result, then reset in the middle of a wait
        do_reset();
        bus.r_ready = 0;
        m_low = 1; m_high = 4;
        base = res_n;
        push(16'h0408, 8'd3, acc);
        for (int i = 0; i < 100 && !bus.r_valid; i++) @(negedge clk);
        chk("hold_rvalid_seen", 64'(bus.r_valid), 64'd1);
        c_cls = bus.r_class; c_tag = bus.r_tag; c_st = bus.r_status;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!bus.r_valid || bus.r_class !== c_cls || bus.r_tag !== c_tag || bus.r_status !== c_st)
                bad++;
        end
        chk("hold_stable", 64'(bad), 64'd0);
        @(posedge clk); #1;
        bus.r_ready = 1;
        @(posedge clk); #1;
        chk("hold_rvalid_drop", 64'(bus.r_valid), 64'd0);
        v = '{16'h0408, 8'd3, 1'b1, 4'd0, 2'b00};
        chk_res("hold", base, v, r);

        m_never = 1;
        sb = starts;
        push(16'h0203, 8'd5, acc);
        wait_start(sb);
        repeat (5) @(negedge clk);
        #2;
        chk("midwait_busy", 64'(busy), 64'd1);
        rst_n = 0;
        #1;
        chk_zero("midwait_reset_outputs");
        rn = res_n;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        m_never = 0;
        repeat (3) @(negedge clk);
        chk("midwait_no_result", 64'(res_n), 64'(rn));
        push(16'h0707, 8'd3, acc);
        v = '{16'h0707, 8'd3, 1'b0, 4'd0, 2'b00};
        chk_res("post_reset", rn, v, r);

        chk("q_count_max", 64'(qmax), 64'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/knn_query_sequencer.md
Name: knn_query_sequencer

Overview:
- Host-side initiator for the k-NN classifier: drives its start / test_data / k_value inputs and collects done / predicted_class.
- Buffers incoming queries in a small FIFO and issues them to the classifier one at a time.
- Returns each result tagged with its query sequence number and a status code. Sits between the query source (DMA/host interface) and knn_classifier.

Parameters:
DATA_WIDTH, 8, width of one feature and of k
NUM_FEATURES, 2, features per test point
FIFO_DEPTH, 4, query FIFO entries (power of 2, >=2)
TAG_WIDTH, 4, result tag width
MAX_K, 15, largest legal k
TIMEOUT_CYCLES, 4096, max WAIT cycles before abort

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
q_valid  in  1  query valid
q_ready  out  1  query FIFO can accept
q_data  in  DATA_WIDTH*NUM_FEATURES  test point, feature 0 in MSBs
q_k  in  DATA_WIDTH  k for this query
knn_start  out  1  one-cycle start pulse to classifier
knn_test_data  out  DATA_WIDTH*NUM_FEATURES  test point to classifier
knn_k_value  out  DATA_WIDTH  k to classifier
knn_done  in  1  classifier done (level)
knn_class  in  1  classifier predicted_class
r_valid  out  1  result valid
r_ready  in  1  result consumer ready
r_class  out  1  result class
r_tag  out  TAG_WIDTH  sequence number of the query
r_status  out  2  00 ok, 01 timeout, 10 bad_k
busy  out  1  FSM not IDLE
q_count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst_n low, async): FIFO emptied, tag counter 0, FSM IDLE. All outputs 0, including q_ready, which is forced 0 while rst_n is low. Reset mid-query abandons it; no result is produced.
- Query accept: on q_valid && q_ready at a rising edge, store {q_data, q_k, tag}, then tag increments mod 2^TAG_WIDTH. q_ready = !full (registered occupancy). A push while full is impossible because q_ready is low.
- FSM states: IDLE, ISSUE, WAIT, RESULT. All outputs are registered.
- IDLE: if FIFO non-empty, pop the head into the working registers. If head k==0 or k>MAX_K, go to RESULT with status 10 and class 0. Otherwise go to ISSUE.
- ISSUE: knn_start=1 for exactly this one cycle. knn_test_data/knn_k_value hold the working values from ISSUE until the next pop. Next state WAIT; clear timer and armed flag.
- WAIT: armed flag sets the first cycle knn_done is sampled low. Completion is knn_done high while armed, so a stale done left high from the previous query is ignored. On completion, capture knn_class and go to RESULT with status 00.
- WAIT timeout: timer counts WAIT cycles. When it reaches TIMEOUT_CYCLES-1 without completion, go to RESULT with status 01 and class 0. Completion and timeout in the same cycle: completion wins.
- RESULT: r_valid=1 with r_class/r_tag/r_status stable until r_ready is sampled high, then go to IDLE. r_valid drops the cycle after the handshake.
- Back-to-back queries: at least one IDLE cycle between results. No pipelining; at most one query is outstanding at the classifier.
- Latency with the FIFO empty and FSM IDLE, query accepted at edge E:
  - IDLE at E+1.
  - knn_start high in the cycle after E+1.
  - r_valid high in the cycle after completion is sampled.
- bad_k latency: r_valid high the cycle after the pop; knn_start never asserts.
- FIFO simultaneous push and pop (non-full): both take effect; occupancy unchanged. Pointers wrap mod FIFO_DEPTH.
- busy = (state != IDLE). q_count reflects occupancy after each edge.

Test Plan:
- Reset, then one query (4,8) with k=3; classifier model raises done 20 cycles after start with class 1.
  -> exactly one knn_start pulse; knn_test_data=16'h0408; r_valid with class 1, tag 0, status 00.
- Push 5 queries back-to-back with r_ready=1: (4,8),(2,3),(7,7),(1,1) with k=5, then (8,8).
  -> q_ready drops after 4 are stored while the first is in flight; results arrive in order with tags 0..4; q_count never exceeds 4.
- Model holds done high after the previous query and lowers it 2 cycles after the new start.
  -> the sequencer does not complete until the new done rise; class is taken from the new result.
- Model never raises done, TIMEOUT_CYCLES=64.
  -> r_valid with status 01, class 0 at WAIT cycle 64; the next queued query is then issued normally.
- Queries with k=0 and k=16 -> status 10 each, no knn_start pulse, tags consumed in order.
- Hold r_ready=0 for 10 cycles, then deassert rst_n mid-WAIT on a later query.
  -> result stays stable while r_ready=0; after reset all outputs are 0, q_count=0, and the next accepted query gets tag 0.
